// File: rtl/reg_dump_ctrl.sv
// reg_dump_ctrl
//   Sequential read-side controller for the 32x32 register file. A start pulse
//   walks the register file read port (rs) from first_addr to last_addr
//   (inclusive, wrapping modulo 2**ADDR_W). Each word is captured from the
//   combinational busA and streamed out over a valid/ready interface. The
//   register file is never written.
//
//   Optional feature, macro REG_DUMP_CHECKSUM_EN:
//     defined   - a running XOR of the captured words is appended as one extra
//                 word (out_addr=0, out_csum=1, out_last=1).
//     undefined - no accumulator, out_csum stays 0, out_last marks the final
//                 register word.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous, active-high reset
//   start      one-cycle dump request, sampled only in IDLE
//   first_addr first register to dump (sampled with start)
//   last_addr  last register to dump, inclusive (sampled with start)
//   rd_addr    register file rs address (0 outside SCAN)
//   rd_data    register file busA, combinational from rd_addr
//   out_valid  out_data/out_addr/out_last/out_csum are valid
//   out_ready  consumer accepts the word when out_valid & out_ready
//   out_data   captured register word (or checksum)
//   out_addr   register index of out_data
//   out_last   final word of the dump
//   out_csum   checksum word marker
//   busy       high in SCAN and DRAIN
//   done       one-cycle pulse after the final word handshake
module reg_dump_ctrl #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] first_addr,
   input  logic [ADDR_W-1:0] last_addr,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last,
   output logic              out_csum,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   cur_addr, cur_addr_nxt;
   logic [ADDR_W:0]     remaining, remaining_nxt;
   logic                out_valid_nxt;
   logic [DATA_W-1:0]   out_data_nxt;
   logic [ADDR_W-1:0]   out_addr_nxt;
   logic                out_last_nxt;
   logic                out_csum_nxt;
   logic [ADDR_W-1:0]   span;
   logic                handshake;
   logic                load;
   logic                final_reg;
`ifdef REG_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0]   csum_acc, csum_acc_nxt;
`endif

   // Modulo subtraction gives the wrapped distance; +1 makes the range inclusive
   // so remaining spans 1..2**ADDR_W and needs one extra bit.
   assign span      = last_addr - first_addr;
   assign handshake = out_valid & out_ready;
   assign load      = (!out_valid | out_ready) & (remaining != '0);
   assign final_reg = (remaining == (ADDR_W+1)'(1));

   assign rd_addr = (state == SCAN) ? cur_addr : '0;
   assign busy    = (state == SCAN) || (state == DRAIN);
   assign done    = (state == DONE);

   always_comb begin
      state_nxt     = state;
      cur_addr_nxt  = cur_addr;
      remaining_nxt = remaining;
      out_valid_nxt = out_valid;
      out_data_nxt  = out_data;
      out_addr_nxt  = out_addr;
      out_last_nxt  = out_last;
      out_csum_nxt  = out_csum;
`ifdef REG_DUMP_CHECKSUM_EN
      csum_acc_nxt  = csum_acc;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               cur_addr_nxt  = first_addr;
               remaining_nxt = {1'b0, span} + (ADDR_W+1)'(1);
`ifdef REG_DUMP_CHECKSUM_EN
               csum_acc_nxt  = '0;
`endif
               state_nxt     = SCAN;
            end
         end
         SCAN: begin
            if (load) begin
               out_data_nxt  = rd_data;
               out_addr_nxt  = cur_addr;
               out_valid_nxt = 1'b1;
               out_csum_nxt  = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
               // The checksum word carries out_last, not the last register word.
               out_last_nxt  = 1'b0;
               csum_acc_nxt  = csum_acc ^ rd_data;
`else
               out_last_nxt  = final_reg;
`endif
               cur_addr_nxt  = cur_addr + ADDR_W'(1);
               remaining_nxt = remaining - (ADDR_W+1)'(1);
               if (final_reg) begin
                  state_nxt = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (handshake) begin
               if (out_last) begin
                  out_valid_nxt = 1'b0;
                  state_nxt     = DONE;
               end
`ifdef REG_DUMP_CHECKSUM_EN
               else begin
                  // Last register word accepted; replace it with the checksum.
                  out_data_nxt = csum_acc;
                  out_addr_nxt = '0;
                  out_last_nxt = 1'b1;
                  out_csum_nxt = 1'b1;
               end
`endif
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cur_addr  <= '0;
         remaining <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
         out_last  <= 1'b0;
         out_csum  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
         csum_acc  <= '0;
`endif
      end else begin
         state     <= state_nxt;
         cur_addr  <= cur_addr_nxt;
         remaining <= remaining_nxt;
         out_valid <= out_valid_nxt;
         out_data  <= out_data_nxt;
         out_addr  <= out_addr_nxt;
         out_last  <= out_last_nxt;
         out_csum  <= out_csum_nxt;
`ifdef REG_DUMP_CHECKSUM_EN
         csum_acc  <= csum_acc_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Testbench for reg_dump_ctrl: a register file array in the bench feeds
// rd_data; each dump request pushes its expected word stream into a queue and
// a negedge monitor pops and compares on every output handshake.
module tb_reg_dump_ctrl;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int NREG   = 32;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] first_addr = '0;
   logic [ADDR_W-1:0] last_addr = '0;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [DATA_W-1:0] out_data;
   logic [ADDR_W-1:0] out_addr;
   logic              out_last;
   logic              out_csum;
   logic              busy;
   logic              done;

   logic [DATA_W-1:0] regs [NREG];
   assign rd_data = regs[rd_addr];

   always #5 clk = ~clk;

   reg_dump_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .start(start),
      .first_addr(first_addr), .last_addr(last_addr),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_addr(out_addr),
      .out_last(out_last), .out_csum(out_csum),
      .busy(busy), .done(done)
   );

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] addr;
      logic              last;
      logic              csum;
      logic              fin;
   } word_t;

   word_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   logic  exp_busy = 1'b0;
   logic  exp_done = 1'b0;
   logic  stall_prev = 1'b0;
   logic [DATA_W-1:0] hold_data;
   logic [ADDR_W-1:0] hold_addr;
   logic              hold_last;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
      end
   endtask

   // Reference: the dump is the inclusive wrapped range first..last, each word
   // being the register value at that index; optional XOR word appended.
   function automatic void model_dump(input int first, input int last);
      int n;
      int a;
      word_t w;
      logic [DATA_W-1:0] x;
      n = ((last - first) % NREG + NREG) % NREG + 1;
      x = '0;
      for (int i = 0; i < n; i++) begin
         a = (first + i) % NREG;
         w.data = regs[a];
         w.addr = a[ADDR_W-1:0];
         w.csum = 1'b0;
         w.last = (i == n - 1);
         w.fin  = (i == n - 1);
         x = x ^ regs[a];
`ifdef REG_DUMP_CHECKSUM_EN
         w.last = 1'b0;
         w.fin  = 1'b0;
`endif
         exp_q.push_back(w);
      end
`ifdef REG_DUMP_CHECKSUM_EN
      w.data = x;
      w.addr = '0;
      w.last = 1'b1;
      w.csum = 1'b1;
      w.fin  = 1'b1;
      exp_q.push_back(w);
`endif
   endfunction

   // Monitor / scoreboard
   always @(negedge clk) begin
      word_t w;
      logic nb;
      logic nd;
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("done", 64'(done), 64'(exp_done));
      if (stall_prev) begin
         chk("stall_valid", 64'(out_valid), 64'd1);
         chk("stall_data", 64'(out_data), 64'(hold_data));
         chk("stall_addr", 64'(out_addr), 64'(hold_addr));
         chk("stall_last", 64'(out_last), 64'(hold_last));
      end
      nb = exp_busy;
      nd = 1'b0;
      if (reset) begin
         exp_q.delete();
         nb = 1'b0;
      end else begin
         if (out_valid === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL spurious_word: got addr %0d data 0x%0h with nothing expected", out_addr, out_data);
            end else begin
               w = exp_q.pop_front();
               chk("data", 64'(out_data), 64'(w.data));
               chk("addr", 64'(out_addr), 64'(w.addr));
               chk("last", 64'(out_last), 64'(w.last));
               chk("csum", 64'(out_csum), 64'(w.csum));
               if (w.fin) begin
                  nb = 1'b0;
                  nd = 1'b1;
               end
            end
         end
         if (start && !exp_busy && !exp_done) nb = 1'b1;
      end
      stall_prev = (out_valid === 1'b1) && !out_ready && !reset;
      hold_data  = out_data;
      hold_addr  = out_addr;
      hold_last  = out_last;
      exp_busy   = nb;
      exp_done   = nd;
   end

   // mode: 0 ready high, 1 random, 2 toggling, 3 low for 4 valid cycles
   task automatic run_dump(input int first, input int last, input int mode, input bit poke);
      int cyc;
      int vcnt;
      bit got;
      cyc = 0;
      vcnt = 0;
      got = 1'b0;
      @(posedge clk); #1;
      first_addr = first[ADDR_W-1:0];
      last_addr  = last[ADDR_W-1:0];
      start      = 1'b1;
      model_dump(first, last);
      out_ready  = (mode != 3);
      while (!got && cyc < 400) begin
         @(posedge clk); #1;
         cyc++;
         start = poke && (cyc == 1);
         if (start) begin
            first_addr = ADDR_W'($urandom_range(0, NREG - 1));
            last_addr  = ADDR_W'($urandom_range(0, NREG - 1));
         end
         if (out_valid) vcnt++;
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            2: out_ready = ~out_ready;
            default: out_ready = (vcnt > 4);
         endcase
         if (done) got = 1'b1;
      end
      start = 1'b0;
      chk("dump_completed", 64'(got), 64'd1);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_out_data"}, 64'(out_data), 64'd0);
      chk({tag, "_out_addr"}, 64'(out_addr), 64'd0);
      chk({tag, "_out_last"}, 64'(out_last), 64'd0);
      chk({tag, "_out_csum"}, 64'(out_csum), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cyc;
      for (int i = 0; i < NREG; i++) regs[i] = DATA_W'(32'h100 + i);

      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset");
      reset = 1'b0;

      run_dump(0, 31, 0, 1'b0);
      run_dump(30, 2, 0, 1'b0);
      run_dump(7, 7, 3, 1'b0);
      run_dump(4, 9, 2, 1'b0);
      run_dump(10, 20, 1, 1'b1);

      // Reset in the middle of a full-range dump, once addr 12 is presented.
      @(posedge clk); #1;
      first_addr = '0;
      last_addr  = 5'd31;
      start      = 1'b1;
      model_dump(0, 31);
      out_ready  = 1'b1;
      cyc = 0;
      @(posedge clk); #1;
      start = 1'b0;
      while (!(out_valid && out_addr == 5'd12) && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("reached_addr12", 64'(out_addr), 64'd12);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check_reset_state("midreset");
      repeat (3) @(posedge clk);
      run_dump(3, 3, 0, 1'b0);

      regs[0] = 32'h1;
      regs[1] = 32'h2;
      regs[2] = 32'h4;
      regs[3] = 32'h8;
      run_dump(0, 3, 0, 1'b0);

      for (int k = 0; k < 24; k++) begin
         for (int i = 0; i < NREG; i++) regs[i] = $urandom;
         run_dump($urandom_range(0, NREG - 1), $urandom_range(0, NREG - 1),
                  $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      repeat (3) @(posedge clk);
      #1;
      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
